reaction_time_meter: RTL and testbench

- Measurement stage directly downstream of the reaction-time game FSM.
- Consumes the FSM's `countdown` and `led_on` outputs plus the same `play` button pulse.
- Timestamps the player's press in milliseconds after the LED lights, detects false starts and timeouts, and tracks the best time since reset.
- Outputs feed the seven-segment display driver and the score logic.

---
 rtl/reaction_time_meter.sv | 119 +++++++++++
 tb/tb_reaction_time_meter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_time_meter.sv
// Reaction-time measurement stage.
// Sits behind the game FSM. It counts milliseconds from LED-on to the player's
// press, flags false starts and timeouts, and keeps the best time since reset.
module reaction_time_meter #(
    parameter  int CLK_FREQ_HZ  = 50_000_000,
    parameter  int MAX_MS       = 4095,
    localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000,
    localparam int W            = $clog2(MAX_MS),
    localparam int PW           = $clog2(TICKS_PER_MS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         play,
    input  logic         countdown,
    input  logic         led_on,
    output logic [W-1:0] reaction_ms,
    output logic [W-1:0] best_ms,
    output logic         result_valid,
    output logic         false_start,
    output logic         timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_LED, TIMING, HOLD} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] prescaler;
    logic [W-1:0]  count;
    logic          ms_tick;
    logic          enter_timing, capture, expire, set_fs;

    // The prescaler only advances while timing, so a tick can only occur in TIMING.
    assign ms_tick = (state == TIMING) && (prescaler == PW'(TICKS_PER_MS - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus one-cycle strobes. In TIMING, a press wins over a timeout,
    // and a timeout wins over the LED turning off.
    always_comb begin
        state_nxt    = state;
        enter_timing = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;
        set_fs       = 1'b0;
        case (state)
            IDLE: if (countdown) state_nxt = WAIT_LED;
            WAIT_LED: begin
                if (play && !led_on) begin
                    set_fs    = 1'b1;
                    state_nxt = IDLE;
                end else if (led_on) begin
                    enter_timing = 1'b1;
                    state_nxt    = TIMING;
                end else if (!countdown) begin
                    state_nxt = IDLE;
                end
            end
            TIMING: begin
                if (play) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (ms_tick && count == W'(MAX_MS - 1)) begin
                    expire    = 1'b1;
                    state_nxt = HOLD;
                end else if (!led_on) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: if (!led_on) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Millisecond timebase. Both counters restart on each entry to TIMING, so the
    // first increment of count lands TICKS_PER_MS cycles after entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            count     <= '0;
        end else if (enter_timing) begin
            prescaler <= '0;
            count     <= '0;
        end else if (state == TIMING) begin
            prescaler <= ms_tick ? '0 : prescaler + PW'(1);
            if (ms_tick && count != W'(MAX_MS)) count <= count + W'(1);
        end
    end

    // Result registers. A capture stores the pre-increment count, even when it
    // coincides with a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reaction_ms  <= '0;
            best_ms      <= W'(MAX_MS);
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= capture | expire;
            if (capture) begin
                reaction_ms <= count;
                if (count < best_ms) best_ms <= count;
            end
            if (expire) begin
                reaction_ms <= W'(MAX_MS);
                timeout     <= 1'b1;
            end
            if (set_fs) false_start <= 1'b1;
            if (enter_timing) begin
                false_start <= 1'b0;
                timeout     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reaction_time_meter.sv
// Self-checking bench for reaction_time_meter.
// A behavioural model derives the expected outputs from how long the LED has
// been lit. That model is compared against the DUT on every falling edge.
// Literal checks at key points pin down the model itself.
module tb_reaction_time_meter;

    localparam int T   = 10;     // ticks per ms at 10 kHz
    localparam int MAX = 4095;
    localparam int W   = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         play = 1'b0;
    logic         countdown = 1'b0;
    logic         led_on = 1'b0;
    logic [W-1:0] reaction_ms;
    logic [W-1:0] best_ms;
    logic         result_valid;
    logic         false_start;
    logic         timeout;

    int n_cmp = 0;
    int n_bad = 0;

    reaction_time_meter #(.CLK_FREQ_HZ(10_000), .MAX_MS(MAX)) dut (
        .clk(clk), .reset(reset), .play(play), .countdown(countdown), .led_on(led_on),
        .reaction_ms(reaction_ms), .best_ms(best_ms), .result_valid(result_valid),
        .false_start(false_start), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 armed (waiting for LED), 2 LED lit and timing, 3 result held.
    // el counts the clock edges seen since the LED-on edge. The count held at
    // that point is el/T whole milliseconds.
    int ph, el, m_react, m_best;
    bit m_rv, m_fs, m_to;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= 0; el <= 0; m_react <= 0; m_best <= MAX;
            m_rv <= 0; m_fs <= 0; m_to <= 0;
        end else begin
            m_rv <= 0;
            case (ph)
                0: if (countdown) ph <= 1;
                1: begin
                    if (play && !led_on) begin m_fs <= 1; ph <= 0; end
                    else if (led_on) begin ph <= 2; el <= 0; m_fs <= 0; m_to <= 0; end
                    else if (!countdown) ph <= 0;
                end
                2: begin
                    el <= el + 1;
                    if (play) begin
                        m_react <= el / T;
                        m_rv    <= 1;
                        if (el / T < m_best) m_best <= el / T;
                        ph <= 3;
                    end else if (el + 1 == MAX * T) begin
                        m_react <= MAX; m_rv <= 1; m_to <= 1; ph <= 3;
                    end else if (!led_on) ph <= 0;
                end
                default: if (!led_on) ph <= 0;
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("reaction_ms",  int'(reaction_ms),  m_react);
        check("best_ms",      int'(best_ms),      m_best);
        check("result_valid", int'(result_valid), int'(m_rv));
        check("false_start",  int'(false_start),  int'(m_fs));
        check("timeout",      int'(timeout),      int'(m_to));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_play();
        play = 1'b1; tick(1); play = 1'b0;
    endtask

    // kind 0: press n cycles after LED on, then a press that must be ignored in hold
    // kind 1: false start during countdown
    // kind 2: LED drops after n cycles with no press
    // kind 3: press in the same cycle the LED drops
    task automatic do_round(input int kind, input int n);
        if ($urandom_range(0, 1) == 1) begin pulse_play(); tick(1); end  // idle press
        countdown = 1'b1;
        tick(2 + $urandom_range(0, 3));
        if (kind == 1) begin
            pulse_play();
            countdown = 1'b0;
            tick(3);
            return;
        end
        countdown = 1'b0;
        led_on = 1'b1;
        tick(n);
        case (kind)
            0: begin pulse_play(); tick(2); pulse_play(); end
            3: begin play = 1'b1; led_on = 1'b0; tick(1); play = 1'b0; end
            default: ;
        endcase
        led_on = 1'b0;
        tick(3);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst reaction_ms", int'(reaction_ms), 0);
        check("rst best_ms", int'(best_ms), MAX);
        check("rst result_valid", int'(result_valid), 0);
        check("rst flags", int'({false_start, timeout}), 0);
        @(negedge clk) reset = 1'b0;
        tick(2);

        // basic round
        do_round(0, 253);
        check("basic reaction", int'(reaction_ms), 25);
        check("basic best", int'(best_ms), 25);

        // best tracking: fresh reset so the first round sets best
        #2 reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        do_round(0, 4005);
        check("best after 400", int'(best_ms), 400);
        do_round(0, 1205);
        check("best after 120", int'(best_ms), 120);
        do_round(0, 3005);
        check("best stays 120", int'(best_ms), 120);
        check("reaction 300", int'(reaction_ms), 300);

        // false start, then a valid round clears it
        do_round(1, 0);
        check("false_start set", int'(false_start), 1);
        check("fs keeps reaction", int'(reaction_ms), 300);
        do_round(0, 1505);
        check("false_start cleared", int'(false_start), 0);
        check("reaction 150", int'(reaction_ms), 150);

        // timeout, followed by a press in hold that must be ignored
        do_round(0, 40960);
        check("timeout reaction", int'(reaction_ms), MAX);
        check("timeout flag", int'(timeout), 1);
        check("timeout best", int'(best_ms), 120);

        // reset between edges mid-timing at count=50
        countdown = 1'b1; tick(2);
        countdown = 1'b0; led_on = 1'b1;
        tick(505);
        #2 reset = 1'b1;
        #1;
        check("midrst reaction_ms", int'(reaction_ms), 0);
        check("midrst best_ms", int'(best_ms), MAX);
        check("midrst result_valid", int'(result_valid), 0);
        check("midrst timeout", int'(timeout), 0);
        @(negedge clk) reset = 1'b0;
        led_on = 1'b0;
        tick(3);

        // coincident events
        do_round(0, 80);
        check("press on tick", int'(reaction_ms), 7);
        do_round(3, 333);
        check("press at led drop", int'(reaction_ms), 33);
        check("best after coincident", int'(best_ms), 7);

        // randomized rounds
        repeat (12) do_round($urandom_range(0, 3), $urandom_range(1, 1200));

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
